// File: rtl/delay_tap_calib_ctrl.sv
// Calibration controller for the tap-selectable self-timed delay line: launches 2-phase
// requests, times the synchronised return toggle and steps tap_sel until the target is met.
module delay_tap_calib_ctrl #(
  parameter int TAP_W       = 4,
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE      = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [CNT_W-1:0] target_cycles,
  output logic [TAP_W-1:0] tap_sel,
  output logic             req_out,
  input  logic             ack_in,
  output logic             busy,
  output logic             done,
  output logic [1:0]       status,
  output logic [CNT_W-1:0] measured
);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT, S_EVAL, S_SETTLE, S_FINISH, S_ERROR
  } state_t;

  localparam logic [1:0]       ST_OK       = 2'b00;
  localparam logic [1:0]       ST_SAT      = 2'b01;
  localparam logic [1:0]       ST_TIMEOUT  = 2'b10;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT   = CNT_W'(TIMEOUT);
  localparam logic [TAP_W-1:0] TAP_MAX     = '1;

  state_t                 r_state;
  state_t                 w_next;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       r_target;
  logic [CNT_W-1:0]       r_measured;
  logic [TAP_W-1:0]       r_tap;
  logic                   r_req;
  logic                   r_busy;
  logic                   r_done;
  logic [1:0]             r_status;
  logic                   w_ack_match;
  logic                   w_pass;
  logic                   w_tap_max;

  // The trial is complete once the synchronised return phase catches up with the request phase.
  assign w_ack_match = (r_sync[SYNC_STAGES-1] == r_req);
  assign w_pass      = (r_measured >= r_target);
  assign w_tap_max   = (r_tap == TAP_MAX);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_sync  <= '0;
    end else begin
      // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
      r_state <= w_next;
      r_sync  <= {r_sync[SYNC_STAGES-2:0], ack_in};
    end
  end

  always_comb begin
    // NOTE: default assigned first so no branch leaves w_next unassigned and infers a latch.
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (start) w_next = S_SETTLE;
      S_SETTLE: if (r_cnt == SETTLE_LAST) w_next = S_LAUNCH;
      S_LAUNCH: w_next = S_WAIT;
      S_WAIT: begin
        if (w_ack_match)             w_next = S_EVAL;
        else if (r_cnt == CNT_LIMIT) w_next = S_ERROR;
      end
      S_EVAL:   w_next = (w_pass || w_tap_max) ? S_FINISH : S_SETTLE;
      S_FINISH: w_next = S_IDLE;
      S_ERROR:  w_next = S_ERROR;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cnt      <= '0;
      r_target   <= '0;
      r_measured <= '0;
      r_tap      <= '0;
      r_req      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_status   <= ST_OK;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_target <= target_cycles;
            r_tap    <= '0;
            r_busy   <= 1'b1;
            r_status <= ST_OK;
            r_cnt    <= '0;
          end
        end
        S_SETTLE: r_cnt <= r_cnt + CNT_W'(1);
        S_LAUNCH: begin
          r_req <= ~r_req;
          r_cnt <= '0;
        end
        S_WAIT: begin
          if (w_ack_match) begin
            r_measured <= r_cnt;
          end else if (r_cnt == CNT_LIMIT) begin
            // Phase alignment with the line is lost here; only reset recovers.
            r_measured <= r_cnt;
            r_status   <= ST_TIMEOUT;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_EVAL: begin
          if (w_pass || w_tap_max) begin
            r_status <= w_pass ? ST_OK : ST_SAT;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
          end else begin
            r_tap <= r_tap + TAP_W'(1);
            r_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign tap_sel  = r_tap;
  assign req_out  = r_req;
  assign busy     = r_busy;
  assign done     = r_done;
  assign status   = r_status;
  assign measured = r_measured;

endmodule

// File: tb/tb_delay_tap_calib_ctrl.sv
// Self-checking bench for delay_tap_calib_ctrl: behavioural delay line plus a trial-by-trial
// reference model of the calibration search, with directed and randomized runs.
module tb_delay_tap_calib_ctrl;

  localparam int TAP_W   = 4;
  localparam int CNT_W   = 8;
  localparam int SYNC    = 2;
  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 255;
  localparam int NTAPS   = 1 << TAP_W;

  logic             clk = 1'b0;
  logic             rstn;
  logic             start;
  logic [CNT_W-1:0] target_cycles;
  logic [TAP_W-1:0] tap_sel;
  logic             req_out;
  logic             ack_in;
  logic             busy;
  logic             done;
  logic [1:0]       status;
  logic [CNT_W-1:0] measured;

  int checks = 0;
  int errors = 0;

  // Delay-line behaviour: 0 = direct loopback, 1 = per-tap extra delay table, 2 = stuck at 0.
  int   mode = 0;
  int   ext[NTAPS];
  logic ack_r = 1'b0;
  logic last_req = 1'b0;
  int   dcnt = 0;
  bit   pend = 1'b0;

  delay_tap_calib_ctrl #(
    .TAP_W(TAP_W), .CNT_W(CNT_W), .SYNC_STAGES(SYNC), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .target_cycles(target_cycles),
    .tap_sel(tap_sel), .req_out(req_out), .ack_in(ack_in), .busy(busy),
    .done(done), .status(status), .measured(measured)
  );

  always #5 clk = ~clk;

  // Event-driven line: each request toggle returns ext[tap] cycles later than a bare wire.
  always @(negedge clk) begin
    if (!rstn) begin
      ack_r = 1'b0; last_req = 1'b0; pend = 1'b0; dcnt = 0;
    end else begin
      if (req_out !== last_req) begin
        last_req = req_out;
        dcnt     = ext[tap_sel];
        pend     = 1'b1;
      end
      if (pend) begin
        if (dcnt == 0) begin
          ack_r = last_req;
          pend  = 1'b0;
        end else begin
          dcnt--;
        end
      end
    end
  end

  assign ack_in = (mode == 0) ? req_out : (mode == 1) ? ack_r : 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Search model: trial on tap t measures SYNC + line delay; cycles counted from the start cycle.
  task automatic ref_model(input int tgt, input int md, output int e_cyc, output int e_tap,
                           output int e_meas, output int e_stat);
    int cyc = 0;
    e_tap = 0; e_meas = 0; e_stat = 0;
    for (int t = 0; t < NTAPS; t++) begin
      int m;
      m = (md == 2) ? TIMEOUT + 100 : SYNC + ((md == 1) ? ext[t] : 0);
      e_tap = t;
      if (m > TIMEOUT) begin
        cyc += SETTLE + 1 + TIMEOUT + 1;
        e_meas = TIMEOUT; e_stat = 2;
        break;
      end
      cyc += SETTLE + 1 + (m + 1) + 1;
      e_meas = m;
      if (m >= tgt) begin e_stat = 0; break; end
      if (t == NTAPS - 1) begin e_stat = 1; break; end
    end
    e_cyc = cyc + 1;
  endtask

  task automatic run_cal(input string tag, input int tgt, input int md, input bit noise);
    int k, e_cyc, e_tap, e_meas, e_stat;
    bit busy_ok;
    mode = md;
    ref_model(tgt, md, e_cyc, e_tap, e_meas, e_stat);
    @(negedge clk); target_cycles = CNT_W'(tgt); start = 1'b1;
    @(negedge clk); start = 1'b0;
    if (noise) target_cycles = CNT_W'($urandom);
    k = 1; busy_ok = 1'b1;
    while (!done && k < 2000) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (noise) start = 1'($urandom);
      @(negedge clk); k++;
    end
    start = 1'b0;
    check({tag, "_done_cycle"}, k, e_cyc);
    check({tag, "_tap"}, tap_sel, e_tap);
    check({tag, "_measured"}, measured, e_meas);
    check({tag, "_status"}, status, e_stat);
    check({tag, "_busy_while_running"}, busy_ok, 1);
    check({tag, "_busy_at_done"}, busy, 0);
    @(negedge clk);
    check({tag, "_done_single"}, done, 0);
    check({tag, "_tap_held"}, tap_sel, e_tap);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk); rstn = 1'b0; start = 1'b0;
    repeat (n) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_tap"}, tap_sel, 0);
    check({tag, "_req"}, req_out, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_status"}, status, 0);
    check({tag, "_measured"}, measured, 0);
  endtask

  initial begin
    int k, dones;
    rstn = 1'b0; start = 1'b0; target_cycles = '0;
    for (int t = 0; t < NTAPS; t++) ext[t] = 0;

    repeat (3) @(negedge clk);
    check_cleared("rst_hold");
    rstn = 1'b1;
    @(negedge clk);
    check_cleared("rst_release");

    run_cal("loop_t2", 2, 0, 1'b0);

    for (int t = 0; t < NTAPS; t++) ext[t] = 3 * t;
    run_cal("linear_t10", 10, 1, 1'b0);

    run_cal("loop_sat", 3, 0, 1'b0);
    run_cal("loop_t0", 0, 0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      for (int t = 0; t < NTAPS; t++) ext[t] = $urandom_range(0, 30);
      run_cal($sformatf("rand%0d", r), $urandom_range(0, 40), 1, 1'b1);
    end

    // Reset during the WAIT phase of the third trial (tap 2, line delay 6).
    for (int t = 0; t < NTAPS; t++) ext[t] = 3 * t;
    mode = 1;
    @(negedge clk); target_cycles = 8'd200; start = 1'b1;
    @(negedge clk); start = 1'b0;
    k = 1;
    while (k < 30) begin @(negedge clk); k++; end
    check("midwait_tap", tap_sel, 2);
    check("midwait_measured", measured, 5);
    check("midwait_busy", busy, 1);
    rstn = 1'b0;
    @(negedge clk);
    check_cleared("midwait_rst");
    dones = 0;
    repeat (2) begin @(negedge clk); if (done) dones++; end
    rstn = 1'b1;
    repeat (3) begin @(negedge clk); if (done) dones++; end
    check("midwait_no_done", dones, 0);

    run_cal("timeout", 50, 2, 1'b0);
    @(negedge clk); start = 1'b1; target_cycles = 8'd1;
    @(negedge clk); start = 1'b0;
    dones = 0;
    repeat (20) begin @(negedge clk); if (done || busy) dones++; end
    check("error_sticky_activity", dones, 0);
    check("error_sticky_status", status, 2);
    check("error_sticky_measured", measured, TIMEOUT);

    do_reset(2);
    @(negedge clk);
    check_cleared("recover_rst");
    run_cal("recover_loop_t2", 2, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
